fetch_sequencer: RTL and testbench

Parametrised multi-byte fetch/issue sequencer for the CPU front end. It generalises the single-operand control FSM to instructions carrying 0..MAX_OPS trailing operand bytes at a configurable data width, and adds interrupt entry at instruction boundaries. It sits between the IF stage and ID/EX, steering PC/IR/EX write enables and assembling operand bytes into an immediate bus.

---
 rtl/fetch_seq_pkg.sv | 32 +++
 rtl/fetch_sequencer_operand_capture.sv | 54 +++++
 rtl/fetch_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch/issue sequencer: state encodings,
// opcode field width and the operand-length decoder.
package fetch_seq_pkg;

   // Sequencer state encodings (visible on Current_State)
   localparam logic [2:0] ST_RESET       = 3'b000;
   localparam logic [2:0] ST_FETCH       = 3'b001;
   localparam logic [2:0] ST_FETCH_OP    = 3'b010;
   localparam logic [2:0] ST_EXECUTE_MB  = 3'b011;
   localparam logic [2:0] ST_INTR_SAVE   = 3'b100;
   localparam logic [2:0] ST_INTR_VECTOR = 3'b101;

   // Opcode occupies the top OPC_W bits of an instruction byte
   localparam int OPC_W = 4;

   // Number of trailing operand bytes for an opcode; the two-byte mask wins
   // when both masks claim an opcode, and is disregarded for MAX_OPS < 2.
   function automatic logic [1:0] decode_len(input logic [OPC_W-1:0] opc,
                                             input logic [15:0]      len1_mask,
                                             input logic [15:0]      len2_mask,
                                             input int               max_ops);
      logic [1:0] len;
      len = 2'd0;
      if ((max_ops >= 2) && len2_mask[opc]) begin
         len = 2'd2;
      end else if (len1_mask[opc]) begin
         len = 2'd1;
      end
      return len;
   endfunction

endpackage

// File: rtl/fetch_sequencer_operand_capture.sv
// Operand slot counter and immediate register file. A clear starts a new
// instruction (slot 0, immediate zeroed); a counter reset abandons the
// current instruction but leaves the captured bytes in place.
module fetch_sequencer_operand_capture #(
   parameter int DATA_W  = 8,
   parameter int MAX_OPS = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear_i,
   input  logic                      cnt_rst_i,
   input  logic                      capture_i,
   input  logic [DATA_W-1:0]         data_i,
   output logic [1:0]                slot_o,
   output logic [MAX_OPS*DATA_W-1:0] imm_o
);

   logic [1:0]                cnt_q, cnt_d;
   logic [MAX_OPS*DATA_W-1:0] imm_q, imm_d;

   // Next-state: clear beats counter reset beats capture; otherwise hold
   always_comb begin
      cnt_d = cnt_q;
      imm_d = imm_q;
      if (clear_i) begin
         cnt_d = '0;
         imm_d = '0;
      end else if (cnt_rst_i) begin
         cnt_d = '0;
      end else if (capture_i) begin
         for (int i = 0; i < MAX_OPS; i++) begin
            if (cnt_q == 2'(i)) begin
               imm_d[i*DATA_W +: DATA_W] = data_i;
            end
         end
         cnt_d = cnt_q + 2'd1;
      end
   end

   // Slot counter and immediate storage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         imm_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         imm_q <= imm_d;
      end
   end

   assign slot_o = cnt_q;
   assign imm_o  = imm_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-byte fetch/issue sequencer. Steers PC/IR/EX write enables, gathers
// trailing operand bytes into imm_bus and enters interrupts only at
// instruction boundaries. Outputs are decoded from the registered state and
// then gated by flush/stall; inputs only ever reach the state via registers.
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int          DATA_W    = 8,
   parameter int          MAX_OPS   = 2,
   parameter logic [15:0] LEN1_MASK = 16'h1000,
   parameter logic [15:0] LEN2_MASK = 16'h2000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_W-1:0]         if_instruction,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      intr_req,
   output logic                      PC_Write,
   output logic                      IR_Write,
   output logic                      EX_Write,
   output logic                      PC_Src,
   output logic                      Stack_PC,
   output logic                      Fetch_Op,
   output logic [1:0]                op_idx,
   output logic [MAX_OPS*DATA_W-1:0] imm_bus,
   output logic                      imm_valid,
   output logic                      intr_ack,
   output logic [2:0]                Current_State
);

   logic [2:0] state_q, state_d;
   logic [1:0] len_q, len_d;
   logic [1:0] len_dec;
   logic [1:0] slot;
   logic       in_instr;
   logic       flush_eff;
   logic       stall_eff;
   logic       start;
   logic       capture;

   assign len_dec = decode_len(if_instruction[DATA_W-1 -: OPC_W],
                               LEN1_MASK, LEN2_MASK, MAX_OPS);

   // Flush only matters inside an instruction; interrupt entry is atomic.
   // Stall only holds the real states; RESET and unused codes always move on.
   assign in_instr  = (state_q == ST_FETCH) || (state_q == ST_FETCH_OP) ||
                      (state_q == ST_EXECUTE_MB);
   assign flush_eff = flush && in_instr;
   assign stall_eff = stall && !flush_eff &&
                      (in_instr || (state_q == ST_INTR_SAVE) ||
                       (state_q == ST_INTR_VECTOR));

   // Next-state logic with priority flush > stall > intr_req > normal flow
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      start   = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: begin
            if (flush_eff) begin
               state_d = ST_FETCH;
            end else if (!stall_eff) begin
               if (intr_req) begin
                  state_d = ST_INTR_SAVE;
               end else if (len_dec != 2'd0) begin
                  state_d = ST_FETCH_OP;
                  len_d   = len_dec;
                  start   = 1'b1;
               end
            end
         end
         ST_FETCH_OP: begin
            if (flush_eff) begin
               state_d = ST_FETCH;
            end else if (!stall_eff) begin
               capture = 1'b1;
               if (slot == (len_q - 2'd1)) begin
                  state_d = ST_EXECUTE_MB;
               end
            end
         end
         ST_EXECUTE_MB: begin
            if (flush_eff || !stall_eff) begin
               state_d = ST_FETCH;
            end
         end
         ST_INTR_SAVE: begin
            if (!stall_eff) begin
               state_d = ST_INTR_VECTOR;
            end
         end
         ST_INTR_VECTOR: begin
            if (!stall_eff) begin
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // State and instruction-length registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
         len_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
      end
   end

   fetch_sequencer_operand_capture #(
      .DATA_W (DATA_W),
      .MAX_OPS(MAX_OPS)
   ) u_capture (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (start),
      .cnt_rst_i(flush_eff),
      .capture_i(capture),
      .data_i   (if_instruction),
      .slot_o   (slot),
      .imm_o    (imm_bus)
   );

   // Moore decode of the registered state, then flush/stall gating
   always_comb begin
      PC_Write  = 1'b0;
      IR_Write  = 1'b0;
      EX_Write  = 1'b0;
      PC_Src    = 1'b0;
      Stack_PC  = 1'b0;
      Fetch_Op  = 1'b0;
      op_idx    = 2'd0;
      imm_valid = 1'b0;
      intr_ack  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            PC_Write = 1'b1;
            IR_Write = 1'b1;
            EX_Write = 1'b1;
         end
         ST_FETCH_OP: begin
            PC_Write = 1'b1;
            Fetch_Op = 1'b1;
            op_idx   = slot;
         end
         ST_EXECUTE_MB: begin
            PC_Write  = 1'b1;
            IR_Write  = 1'b1;
            EX_Write  = 1'b1;
            imm_valid = 1'b1;
         end
         ST_INTR_SAVE: Stack_PC = 1'b1;
         ST_INTR_VECTOR: begin
            PC_Src   = 1'b1;
            PC_Write = 1'b1;
            intr_ack = 1'b1;
         end
         default: ;
      endcase
      if (flush_eff) begin
         PC_Write  = 1'b1;
         IR_Write  = 1'b0;
         EX_Write  = 1'b0;
         Fetch_Op  = 1'b0;
         imm_valid = 1'b0;
      end else if (stall_eff) begin
         PC_Write = 1'b0;
         IR_Write = 1'b0;
         EX_Write = 1'b0;
         Stack_PC = 1'b0;
         PC_Src   = 1'b0;
         intr_ack = 1'b0;
      end
   end

   assign Current_State = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by a randomized
// instruction stream whose per-cycle expectations are generated from an
// instruction-level model (n operands -> FETCH, n operand cycles, EXECUTE).
module tb_fetch_sequencer;

   localparam logic [15:0] M1 = 16'h1000;
   localparam logic [15:0] M2 = 16'h2000;
   // Field masks over the packed output vector
   localparam logic [31:0] M_BASE    = 32'h0000_19FF;
   localparam logic [31:0] M_OP      = 32'h0000_1FFF;
   localparam logic [31:0] M_OPSTALL = 32'h0000_1EFF;
   localparam logic [31:0] M_EXE     = 32'h1FFF_F9FF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  if_instruction;
   logic        stall, flush, intr_req;
   logic        PC_Write, IR_Write, EX_Write, PC_Src, Stack_PC, Fetch_Op;
   logic [1:0]  op_idx;
   logic [15:0] imm_bus;
   logic        imm_valid, intr_ack;
   logic [2:0]  Current_State;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [10:0] stim_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] msk_q[$];

   fetch_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_instruction(if_instruction),
      .stall         (stall),
      .flush         (flush),
      .intr_req      (intr_req),
      .PC_Write      (PC_Write),
      .IR_Write      (IR_Write),
      .EX_Write      (EX_Write),
      .PC_Src        (PC_Src),
      .Stack_PC      (Stack_PC),
      .Fetch_Op      (Fetch_Op),
      .op_idx        (op_idx),
      .imm_bus       (imm_bus),
      .imm_valid     (imm_valid),
      .intr_ack      (intr_ack),
      .Current_State (Current_State)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [7:0] b, input logic st, input logic fl, input logic ir);
      if_instruction = b;
      stall          = st;
      flush          = fl;
      intr_req       = ir;
      #1;
   endtask

   // model: operand count from the opcode masks
   function automatic int ref_len(input logic [3:0] opc);
      if (M2[opc]) return 2;
      if (M1[opc]) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] pk(input logic [2:0] st, input logic pcw, input logic irw,
                                      input logic exw, input logic src, input logic stk,
                                      input logic fop, input logic [1:0] idx, input logic iv,
                                      input logic ack, input logic [15:0] imm);
      return {3'b000, imm, ack, iv, idx, fop, stk, src, exw, irw, pcw, st};
   endfunction

   function automatic logic [31:0] obs_pk();
      return pk(Current_State, PC_Write, IR_Write, EX_Write, PC_Src, Stack_PC,
                Fetch_Op, op_idx, imm_valid, intr_ack, imm_bus);
   endfunction

   task automatic push(input logic [10:0] s, input logic [31:0] e, input logic [31:0] m);
      stim_q.push_back(s);
      exp_q.push_back(e);
      msk_q.push_back(m);
   endtask

   task automatic add_stalls(input logic [2:0] st, input logic [1:0] idx, input logic [31:0] m);
      int k;
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      for (int i = 0; i < k; i++)
         push({3'b001, 8'($urandom)}, pk(st, 0, 0, 0, 0, 0, 0, idx, 0, 0, 16'h0), m);
   endtask

   // model: expected cycle trace of one instruction (optionally preceded by an interrupt)
   task automatic gen_instr();
      logic [3:0]  opc;
      logic [7:0]  b;
      logic [15:0] imm;
      int          n;
      if ($urandom_range(0, 5) == 0) begin
         push({3'b100, 8'($urandom)}, pk(3'd1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0), M_BASE);
         push({1'($urandom), 2'b00, 8'($urandom)}, pk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0), M_BASE);
         push({1'($urandom), 2'b00, 8'($urandom)}, pk(3'd5, 1, 0, 0, 1, 0, 0, 0, 0, 1, 16'h0), M_BASE);
      end
      opc = 4'($urandom);
      if ($urandom_range(0, 2) == 0) opc = 4'($urandom_range(12, 13));
      n   = ref_len(opc);
      imm = 16'h0;
      add_stalls(3'd1, 2'd0, M_BASE);
      push({3'b000, opc, 4'($urandom)}, pk(3'd1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0), M_BASE);
      for (int k = 0; k < n; k++) begin
         add_stalls(3'd2, 2'(k), M_OPSTALL);
         b = 8'($urandom);
         imm[k*8 +: 8] = b;
         push({3'b000, b}, pk(3'd2, 1, 0, 0, 0, 0, 1, 2'(k), 0, 0, 16'h0), M_OP);
      end
      if (n > 0)
         push({3'b000, 8'($urandom)}, pk(3'd3, 1, 1, 1, 0, 0, 0, 0, 1, 0, imm), M_EXE);
   endtask

   initial begin
      logic [10:0] s;
      logic [31:0] e, m;

      // reset
      rst_n = 1'b0;
      set_in(8'h00, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_state", 32'(Current_State), 32'd0);
      check_eq("rst_pcw", 32'(PC_Write), 32'd0);
      check_eq("rst_irw", 32'(IR_Write), 32'd0);
      check_eq("rst_imm", 32'(imm_bus), 32'd0);
      rst_n = 1'b1;
      set_in(8'h10, 0, 0, 0);
      check_eq("rel_state", 32'(Current_State), 32'd0);
      tick();

      // zero-operand opcode held: stays in FETCH
      set_in(8'h10, 0, 0, 0);
      check_eq("f0_state", 32'(Current_State), 32'd1);
      check_eq("f0_pcw", 32'(PC_Write), 32'd1);
      check_eq("f0_irw", 32'(IR_Write), 32'd1);
      tick();
      check_eq("f0_stay", 32'(Current_State), 32'd1);

      // one-operand LDM
      set_in(8'hC0, 0, 0, 0);
      tick();
      set_in(8'hAA, 0, 0, 0);
      check_eq("ldm_state", 32'(Current_State), 32'd2);
      check_eq("ldm_fop", 32'(Fetch_Op), 32'd1);
      check_eq("ldm_exw", 32'(EX_Write), 32'd0);
      tick();
      set_in(8'h10, 0, 0, 0);
      check_eq("ldm_ex_state", 32'(Current_State), 32'd3);
      check_eq("ldm_imm", 32'(imm_bus[7:0]), 32'hAA);
      check_eq("ldm_iv", 32'(imm_valid), 32'd1);
      tick();
      check_eq("ldm_back", 32'(Current_State), 32'd1);

      // two-operand with a 3-cycle stall in the first operand slot
      set_in(8'hD0, 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(8'hFF, 1, 0, 0);
         check_eq("stl_state", 32'(Current_State), 32'd2);
         check_eq("stl_idx", 32'(op_idx), 32'd0);
         check_eq("stl_en", {29'd0, PC_Write, IR_Write, EX_Write}, 32'd0);
         tick();
      end
      set_in(8'h12, 0, 0, 0);
      check_eq("d0_idx0", 32'(op_idx), 32'd0);
      tick();
      set_in(8'h34, 0, 0, 0);
      check_eq("d0_idx1", 32'(op_idx), 32'd1);
      tick();
      set_in(8'h10, 0, 0, 0);
      check_eq("d0_state", 32'(Current_State), 32'd3);
      check_eq("d0_imm", 32'(imm_bus), 32'h3412);
      tick();
      check_eq("d0_back", 32'(Current_State), 32'd1);

      // flush during second operand capture
      set_in(8'hD0, 0, 0, 0);
      tick();
      set_in(8'h56, 0, 0, 0);
      tick();
      set_in(8'h78, 0, 1, 0);
      check_eq("fl_pcw", 32'(PC_Write), 32'd1);
      check_eq("fl_en", {30'd0, IR_Write, EX_Write}, 32'd0);
      check_eq("fl_iv", 32'(imm_valid), 32'd0);
      tick();
      set_in(8'h10, 0, 0, 0);
      check_eq("fl_state", 32'(Current_State), 32'd1);
      check_eq("fl_imm", 32'(imm_bus), 32'h0056);
      check_eq("fl_iv2", 32'(imm_valid), 32'd0);
      tick();

      // interrupt entry from FETCH, request held through entry
      set_in(8'h10, 0, 0, 1);
      tick();
      check_eq("in_save", 32'(Current_State), 32'd4);
      check_eq("in_stk", 32'(Stack_PC), 32'd1);
      check_eq("in_pcw0", 32'(PC_Write), 32'd0);
      tick();
      check_eq("in_vec", 32'(Current_State), 32'd5);
      check_eq("in_src", {30'd0, PC_Src, intr_ack}, 32'd3);
      check_eq("in_pcw1", 32'(PC_Write), 32'd1);
      set_in(8'h10, 0, 0, 0);
      tick();
      check_eq("in_back", 32'(Current_State), 32'd1);
      check_eq("in_ack0", 32'(intr_ack), 32'd0);

      // flush during INTR_SAVE is ignored
      set_in(8'h10, 0, 0, 1);
      tick();
      set_in(8'h10, 0, 1, 0);
      check_eq("fi_save", 32'(Current_State), 32'd4);
      check_eq("fi_stk", 32'(Stack_PC), 32'd1);
      tick();
      set_in(8'h10, 0, 0, 0);
      check_eq("fi_vec", 32'(Current_State), 32'd5);
      tick();
      check_eq("fi_back", 32'(Current_State), 32'd1);

      // interrupt raised during operand fetch waits for the boundary
      set_in(8'hC0, 0, 0, 0);
      tick();
      set_in(8'hAB, 0, 0, 1);
      check_eq("dfr_op", 32'(Current_State), 32'd2);
      tick();
      check_eq("dfr_ex", 32'(Current_State), 32'd3);
      check_eq("dfr_imm", 32'(imm_bus), 32'h00AB);
      tick();
      check_eq("dfr_fetch", 32'(Current_State), 32'd1);
      tick();
      check_eq("dfr_save", 32'(Current_State), 32'd4);
      set_in(8'h10, 0, 0, 0);
      tick();
      check_eq("dfr_vec", 32'(Current_State), 32'd5);
      tick();
      check_eq("dfr_back", 32'(Current_State), 32'd1);

      // asynchronous reset in the middle of an instruction
      set_in(8'hD0, 0, 0, 0);
      tick();
      set_in(8'h11, 0, 0, 0);
      check_eq("ar_pre", 32'(Current_State), 32'd2);
      rst_n = 1'b0;
      #1;
      check_eq("ar_state", 32'(Current_State), 32'd0);
      check_eq("ar_out", {29'd0, PC_Write, Fetch_Op, EX_Write}, 32'd0);
      check_eq("ar_imm", 32'(imm_bus), 32'd0);
      tick();
      rst_n = 1'b1;
      set_in(8'h10, 0, 0, 0);
      check_eq("ar_hold", 32'(Current_State), 32'd0);
      tick();
      check_eq("ar_back", 32'(Current_State), 32'd1);

      // randomized instruction stream against the model trace
      for (int i = 0; i < 150; i++) gen_instr();
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         m = msk_q.pop_front();
         set_in(s[7:0], s[8], s[9], s[10]);
         check_eq($sformatf("trace%0d", cyc), obs_pk() & m, e & m);
         cyc++;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
